// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module  : regfile_pkg
// Brief   : Shared constants and state encoding for the regfile write arbiter.
// Rev     : 1.0  initial release
// ============================================================================
package regfile_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 32;
  localparam int NUM_REGS   = 32;

  // CLEAR sweeps the regfile to zero after reset; RUN arbitrates requesters.
  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : rr_arbiter
// Brief   : Round-robin arbiter. The search starts at ptr and wraps; ptr
//           moves one past the winner whenever a grant is consumed.
// Rev     : 1.0  initial release
// ============================================================================
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic [N-1:0]         Req,
  input  logic                 Advance,
  output logic [N-1:0]         Grant,
  output logic [$clog2(N)-1:0] GrantIdx
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] ptr;
  logic          found;
  int            j;

  // First requester at or after ptr, wrapping modulo N, wins.
  always_comb begin
    Grant    = '0;
    GrantIdx = '0;
    found    = 1'b0;
    j        = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!found && Req[j]) begin
        found    = 1'b1;
        Grant[j] = 1'b1;
        GrantIdx = IW'(j);
      end
    end
  end

  // Rotate priority one past the requester that just completed a transfer.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ptr <= '0;
    end else if (Advance) begin
      ptr <= (GrantIdx == IW'(N - 1)) ? '0 : GrantIdx + 1'b1;
    end
  end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : regfile_write_arbiter
// Brief   : Shares the single regfile write port between NUM_REQ requesters
//           with valid/ready handshakes and round-robin fairness.
//           Optional macro REGFILE_CLEAR_EN adds a post-reset CLEAR sweep
//           that zeroes every register before requesters are served.
// Rev     : 1.0  initial release
// ============================================================================
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic                       Clk,
  input  logic                       Reset_n,
  input  logic [NUM_REQ-1:0]         ReqValid,
  input  logic [NUM_REQ*ADDR_W-1:0]  ReqAddr,
  input  logic [NUM_REQ*DATA_W-1:0]  ReqData,
  output logic [NUM_REQ-1:0]         ReqReady,
  output logic [ADDR_W-1:0]          WriteRegister,
  output logic [DATA_W-1:0]          WriteData,
  output logic                       RegWrite,
  output logic [$clog2(NUM_REQ)-1:0] GrantId,
  output logic                       Busy
);

  localparam int IDW = $clog2(NUM_REQ);

  logic               run;
  logic               clearing;
  logic               any_grant;
  logic [NUM_REQ-1:0] arb_req;
  logic [NUM_REQ-1:0] arb_grant;
  logic [IDW-1:0]     arb_idx;

`ifdef REGFILE_CLEAR_EN
  state_t            state;
  logic [ADDR_W-1:0] clear_cnt;

  // Sweep every address once after reset, then hand over to RUN for good.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= CLEAR;
      clear_cnt <= '0;
    end else if (state == CLEAR) begin
      clear_cnt <= clear_cnt + 1'b1;
      if (clear_cnt == {ADDR_W{1'b1}}) state <= RUN;
    end
  end

  assign run      = (state == RUN);
  // Gated with Reset_n so outputs hold reset values while reset is low.
  assign clearing = (state == CLEAR) && Reset_n;
`else
  assign run      = 1'b1;
  assign clearing = 1'b0;
`endif

  assign arb_req   = run ? ReqValid : '0;
  assign any_grant = |arb_grant;
  assign Busy      = clearing;

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_rr_arbiter (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .Req      (arb_req),
    .Advance  (run && any_grant),
    .Grant    (arb_grant),
    .GrantIdx (arb_idx)
  );

  // Write-port mux: clear sweep, granted requester, or idle zeros.
  always_comb begin
    RegWrite      = 1'b0;
    WriteRegister = '0;
    WriteData     = '0;
    ReqReady      = '0;
    GrantId       = '0;
`ifdef REGFILE_CLEAR_EN
    if (clearing) begin
      RegWrite      = 1'b1;
      WriteRegister = clear_cnt;
    end else
`endif
    if (Reset_n && run && any_grant) begin
      RegWrite = 1'b1;
      ReqReady = arb_grant;
      GrantId  = arb_idx;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (arb_grant[i]) begin
          WriteRegister = ReqAddr[i*ADDR_W +: ADDR_W];
          WriteData     = ReqData[i*DATA_W +: DATA_W];
        end
      end
    end
  end

endmodule : regfile_write_arbiter
`default_nettype wire
